// File: rtl/i2c_write_master.sv
// -----------------------------------------------------------------------------
// i2c_write_master
//   Write-only I2C master. A frame is START, address byte {dev_addr,0},
//   NUM_BYTES payload bytes (first byte taken from the top of wdata), STOP.
//   Every START/bit/STOP lasts four quarters of CLK_DIV clocks each. Each ACK
//   slot is sampled at the end of its third quarter. When ACK_CHECK is set, a
//   NACK ends the frame with an immediate STOP.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   start        frame request, accepted only while busy=0
//   dev_addr     7-bit slave address, captured on accept
//   wdata        payload, captured on accept
//   busy         frame in progress
//   done         one-cycle pulse at frame end (normal or aborted)
//   nack         sticky abort flag, cleared on the next accept
//   i2c_sclk     SCL, push-pull
//   i2c_sdat_oe  1 pulls SDA low, 0 releases it
//   i2c_sdat_in  SDA pad readback
// -----------------------------------------------------------------------------
module i2c_write_master #(
   parameter int CLK_DIV   = 125,
   parameter int NUM_BYTES = 2,
   parameter int ACK_CHECK = 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [6:0]             dev_addr,
   input  logic [8*NUM_BYTES-1:0] wdata,
   output logic                   busy,
   output logic                   done,
   output logic                   nack,
   output logic                   i2c_sclk,
   output logic                   i2c_sdat_oe,
   input  logic                   i2c_sdat_in
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int SH_W  = 8 * (NUM_BYTES + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_BIT   = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t            r_state;
   logic [DIV_W-1:0]  r_div;
   logic [1:0]        r_q;
   logic [2:0]        r_bit;
   logic              r_ack_slot;
   logic [3:0]        r_byte;
   logic [SH_W-1:0]   r_shift;
   logic              r_ack_sample;
   logic              r_busy;
   logic              r_done;
   logic              r_nack;
   logic              r_scl;
   logic              r_oe;

   logic              w_qtick;
   logic              w_last_byte;
   logic              w_abort;

   assign w_qtick     = (r_state != S_IDLE) && (r_div == DIV_W'(CLK_DIV - 1));
   assign w_last_byte = (r_byte == 4'(NUM_BYTES));
   assign w_abort     = (ACK_CHECK != 0) && r_ack_sample;

   assign busy        = r_busy;
   assign done        = r_done;
   assign nack        = r_nack;
   assign i2c_sclk    = r_scl;
   assign i2c_sdat_oe = r_oe;

   // Frame sequencer: quarter timing, slot counters and registered bus lines.
   // Line values are updated only on the qtick that enters the new quarter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_div        <= '0;
         r_q          <= 2'd0;
         r_bit        <= 3'd0;
         r_ack_slot   <= 1'b0;
         r_byte       <= 4'd0;
         r_shift      <= '0;
         r_ack_sample <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_nack       <= 1'b0;
         r_scl        <= 1'b1;
         r_oe         <= 1'b0;
      end else begin
         r_done <= 1'b0;

         if (r_state != S_IDLE) begin
            if (w_qtick) begin
               r_div <= '0;
               r_q   <= r_q + 2'd1;
            end else begin
               r_div <= r_div + DIV_W'(1);
            end
         end

         case (r_state)
            S_IDLE: begin
               r_div <= '0;
               r_q   <= 2'd0;
               // busy is still high in the cycle that carries done; a start
               // seen there is dropped, not accepted.
               if (r_busy) begin
                  r_busy <= 1'b0;
               end else if (start) begin
                  r_shift    <= {dev_addr, 1'b0, wdata};
                  r_nack     <= 1'b0;
                  r_busy     <= 1'b1;
                  r_byte     <= 4'd0;
                  r_bit      <= 3'd7;
                  r_ack_slot <= 1'b0;
                  r_state    <= S_START;
               end
            end

            S_START: begin
               if (w_qtick) begin
                  case (r_q)
                     2'd1: r_oe <= 1'b1;
                     2'd3: begin
                        r_state <= S_BIT;
                        r_scl   <= 1'b0;
                        r_oe    <= ~r_shift[SH_W-1];
                        r_shift <= r_shift << 1;
                     end
                     default: ;
                  endcase
               end
            end

            S_BIT: begin
               if (w_qtick) begin
                  case (r_q)
                     2'd1: r_scl <= 1'b1;
                     2'd2: begin
                        if (r_ack_slot) begin
                           r_ack_sample <= i2c_sdat_in;
                        end
                     end
                     2'd3: begin
                        r_scl <= 1'b0;
                        if (!r_ack_slot) begin
                           if (r_bit == 3'd0) begin
                              // Ninth bit: release SDA for the slave.
                              r_ack_slot <= 1'b1;
                              r_oe       <= 1'b0;
                           end else begin
                              r_bit   <= r_bit - 3'd1;
                              r_oe    <= ~r_shift[SH_W-1];
                              r_shift <= r_shift << 1;
                           end
                        end else begin
                           r_ack_slot <= 1'b0;
                           if (w_abort) begin
                              r_nack  <= 1'b1;
                              r_state <= S_STOP;
                              r_oe    <= 1'b1;
                           end else if (w_last_byte) begin
                              r_state <= S_STOP;
                              r_oe    <= 1'b1;
                           end else begin
                              r_byte  <= r_byte + 4'd1;
                              r_bit   <= 3'd7;
                              r_oe    <= ~r_shift[SH_W-1];
                              r_shift <= r_shift << 1;
                           end
                        end
                     end
                     default: ;
                  endcase
               end
            end

            S_STOP: begin
               if (w_qtick) begin
                  case (r_q)
                     2'd0: r_scl <= 1'b1;
                     2'd1: r_oe  <= 1'b0;
                     2'd3: begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_write_master.sv
// -----------------------------------------------------------------------------
// tb_i2c_write_master
//   Four masters share clk/reset_n:
//     g0: CLK_DIV=2, NUM_BYTES=2, ACK_CHECK=1
//     g1: CLK_DIV=2, NUM_BYTES=2, ACK_CHECK=0
//     g2: CLK_DIV=3, NUM_BYTES=1
//     g3: CLK_DIV=3, NUM_BYTES=8
//   Each master has a bus monitor and an ACKing slave that decode START,
//   bytes and STOP from the lines. Expected bytes and frame lengths come from
//   frame-level arithmetic.
// -----------------------------------------------------------------------------
module tb_i2c_write_master;

   int   checks = 0;
   int   errors = 0;
   logic clk     = 1'b0;
   logic reset_n = 1'b1;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int CDV  = (g < 2) ? 2 : 3;
      localparam int NBV  = (g < 2) ? 2 : ((g == 2) ? 1 : 8);
      localparam int ACKV = (g == 1) ? 0 : 1;

      logic             start    = 1'b0;
      logic [6:0]       dev_addr = 7'd0;
      logic [8*NBV-1:0] wdata    = '0;
      logic             busy, done, nack, scl, oe;
      logic             pull     = 1'b0;
      wire              sda      = ~(oe | pull);

      int         nack_at  = -1;    // byte index the slave refuses
      logic [7:0] rx_q[$];
      int         n_start  = 0;
      int         n_stop   = 0;
      int         bitcnt   = 0;
      int         byte_idx = 0;
      int         ncyc     = 0;
      int         nrise    = 0;
      int         rise1    = 0;
      int         rise2    = 0;
      logic       prev_scl = 1'b1;
      logic       prev_sda = 1'b1;
      logic [7:0] sh       = 8'd0;

      i2c_write_master #(
         .CLK_DIV   (CDV),
         .NUM_BYTES (NBV),
         .ACK_CHECK (ACKV)
      ) u_dut (
         .clk         (clk),
         .reset_n     (reset_n),
         .start       (start),
         .dev_addr    (dev_addr),
         .wdata       (wdata),
         .busy        (busy),
         .done        (done),
         .nack        (nack),
         .i2c_sclk    (scl),
         .i2c_sdat_oe (oe),
         .i2c_sdat_in (sda)
      );

      // Bus monitor and slave: decode START/STOP/bytes and drive the ACK bit.
      always @(negedge clk) begin
         ncyc     <= ncyc + 1;
         prev_scl <= scl;
         prev_sda <= sda;
         if (!reset_n) begin
            pull   <= 1'b0;
            bitcnt <= 0;
         end else if (scl && prev_scl && prev_sda && !sda) begin
            n_start  <= n_start + 1;
            bitcnt   <= 0;
            byte_idx <= 0;
            nrise    <= 0;
         end else if (scl && prev_scl && !prev_sda && sda) begin
            n_stop <= n_stop + 1;
         end else if (scl && !prev_scl) begin
            nrise <= nrise + 1;
            if (nrise == 0) rise1 <= ncyc;
            if (nrise == 1) rise2 <= ncyc;
            if (bitcnt == 8) begin
               bitcnt   <= 0;
               byte_idx <= byte_idx + 1;
            end else begin
               sh     <= {sh[6:0], sda};
               bitcnt <= bitcnt + 1;
               if (bitcnt == 7) rx_q.push_back({sh[6:0], sda});
            end
         end else if (!scl && prev_scl) begin
            pull <= (bitcnt == 8) && (byte_idx != nack_at);
         end
      end

      // Bytes that actually reach the bus when the slave NACKs byte k.
      function automatic int sent_bytes(input int k);
         if (ACKV != 0 && k >= 0 && k <= NBV) return k + 1;
         return NBV + 1;
      endfunction

      task automatic run(input logic [6:0] a, input logic [63:0] d, input int k,
                         input int exp_len, input logic exp_nack, input bit poke);
         int         n;
         int         s0;
         int         p0;
         bit         got;
         logic [7:0] exp_q[$];
         exp_q.push_back({a, 1'b0});
         for (int i = 0; i < NBV; i++) exp_q.push_back(d[8*(NBV-1-i) +: 8]);
         while (exp_q.size() > sent_bytes(k)) exp_q.pop_back();

         @(negedge clk);
         rx_q.delete();
         nack_at  = k;
         s0       = n_start;
         p0       = n_stop;
         dev_addr = a;
         wdata    = d[8*NBV-1:0];
         start    = 1'b1;
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         chk("busy_after_accept", busy, 1'b1);
         chk("nack_cleared_on_accept", nack, 1'b0);
         dev_addr = ~a;
         wdata    = ~wdata;
         n   = 0;
         got = 1'b0;
         while (n < 5000 && !got) begin
            if (done) begin
               got = 1'b1;
            end else begin
               start = poke && (n == 10 || n == 100);
               @(negedge clk);
               n++;
            end
         end
         chk("done_seen", got, 1'b1);
         chk("frame_len", n, exp_len);
         chk("busy_on_done", busy, 1'b1);
         chk("nack_flag", nack, exp_nack);
         if (poke) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk("busy_after_done", busy, 1'b0);
         chk("done_one_cycle", done, 1'b0);
         @(negedge clk);
         chk("no_restart", busy, 1'b0);
         chk("byte_count", rx_q.size(), exp_q.size());
         for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) chk("sda_byte", rx_q[i], exp_q[i]);
         end
         chk("start_count", n_start - s0, 1);
         chk("stop_count", n_stop - p0, 1);
         chk("scl_period", rise2 - rise1, 4 * CDV);
      endtask

      task automatic run_rand();
         logic [6:0]  a;
         logic [63:0] d;
         int          k;
         a = 7'($urandom);
         d = {$urandom, $urandom};
         k = int'($urandom_range(NBV + 2)) - 1;
         run(a, d, k, CDV * (8 + 36 * sent_bytes(k)),
             (ACKV != 0 && k >= 0 && k <= NBV), 1'($urandom_range(1)));
      endtask

      task automatic reset_mid();
         int n;
         int p0;
         @(negedge clk);
         nack_at  = -1;
         dev_addr = 7'h1A;
         wdata    = '1;
         start    = 1'b1;
         @(negedge clk);
         start = 1'b0;
         n = 0;
         while (n < 2000 && !(scl == 1'b0 && oe == 1'b1)) begin
            @(negedge clk);
            n++;
         end
         chk("reset_setup_scl_low", {scl, oe}, 2'b01);
         p0 = n_stop;
         @(posedge clk);
         #2 reset_n = 1'b0;
         #1;
         chk("reset_scl", scl, 1'b1);
         chk("reset_oe", oe, 1'b0);
         chk("reset_busy", busy, 1'b0);
         chk("reset_done", done, 1'b0);
         chk("reset_nack", nack, 1'b0);
         @(negedge clk);
         @(posedge clk);
         #2 reset_n = 1'b1;
         repeat (20) @(negedge clk);
         chk("reset_stays_idle", busy, 1'b0);
         chk("reset_no_stop", n_stop - p0, 0);
      endtask
   end

   typedef struct {
      logic [6:0]  addr;
      logic [15:0] data;
      int          nack_at;
      int          exp_len;
      logic        exp_nack;
      bit          poke;
   } vec_t;

   vec_t tbl[6];

   initial begin
      tbl[0] = '{7'h1A, 16'h1E00, -1, 232, 1'b0, 1'b0};
      tbl[1] = '{7'h1A, 16'h1E00,  0,  88, 1'b1, 1'b0};
      tbl[2] = '{7'h55, 16'hA5C3, -1, 232, 1'b0, 1'b1};
      tbl[3] = '{7'h7F, 16'hFFFF,  1, 160, 1'b1, 1'b0};
      tbl[4] = '{7'h00, 16'h0001,  2, 232, 1'b1, 1'b0};
      tbl[5] = '{7'h2B, 16'h8001, -1, 232, 1'b0, 1'b1};

      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", g_dut[0].busy, 1'b0);
      chk("rst_done", g_dut[0].done, 1'b0);
      chk("rst_nack", g_dut[0].nack, 1'b0);
      chk("rst_scl", g_dut[0].scl, 1'b1);
      chk("rst_oe", g_dut[0].oe, 1'b0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", g_dut[0].busy, 1'b0);

      for (int i = 0; i < 6; i++) begin
         g_dut[0].run(tbl[i].addr, 64'(tbl[i].data), tbl[i].nack_at,
                      tbl[i].exp_len, tbl[i].exp_nack, tbl[i].poke);
      end

      g_dut[1].run(7'h1A, 64'h1E00, 1, 232, 1'b0, 1'b0);
      g_dut[2].run(7'h3C, 64'hA7, -1, 240, 1'b0, 1'b0);
      g_dut[3].run(7'h11, 64'h0123_4567_89AB_CDEF, -1, 996, 1'b0, 1'b0);

      g_dut[0].reset_mid();

      for (int r = 0; r < 6; r++) begin
         g_dut[0].run_rand();
         g_dut[1].run_rand();
         g_dut[2].run_rand();
         g_dut[3].run_rand();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
